// File: rtl/rgmii_tx_sink.sv
// rgmii_tx_sink: PHY-side receiver for the MAC's RGMII transmit stream.
// Takes de-DDR'd nibble pairs, strips preamble/SFD, rebuilds GMII bytes at
// 10/100/1000M and reports frame boundaries, errors and frame counters.
// Optional in-band link status outputs: define RGMII_TX_SINK_INBAND_STATUS_EN.
//
// A "unit" is one sampled symbol: a byte every clock at 1000M, or at 10/100 a
// nibble captured on sample_rise_i and completed (with its error bit) on the
// following sample_fall_i. Every unit is processed on the clock it completes,
// so its result appears one clock later.
//
// state | meaning
// IDLE  | between frames, waiting for TX_EN
// PRE   | counting preamble units, waiting for SFD
// DATA  | assembling and emitting payload bytes
// DROP  | malformed start, discard until TX_EN drops
module rgmii_tx_sink #(
    parameter int cnt_width_p    = 16,
    parameter int min_preamble_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [1:0]             speed_i,
    input  logic                   sample_rise_i,
    input  logic                   sample_fall_i,
    input  logic [3:0]             txd_1_i,
    input  logic [3:0]             txd_2_i,
    input  logic                   tx_ctl_1_i,
    input  logic                   tx_ctl_2_i,
    output logic [7:0]             rx_data_o,
    output logic                   rx_v_o,
    output logic                   rx_er_o,
    output logic                   frame_start_o,
    output logic                   frame_end_o,
    output logic                   frame_bad_o,
    output logic [cnt_width_p-1:0] frame_count_o,
    output logic [cnt_width_p-1:0] err_count_o
`ifdef RGMII_TX_SINK_INBAND_STATUS_EN
    ,
    output logic                   link_o,
    output logic [1:0]             link_speed_o,
    output logic                   duplex_o
`endif
);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    localparam logic [7:0] min_pre = 8'(min_preamble_p);

    state_t     state, state_nxt;
    logic [1:0] speed_q;
    logic [3:0] nib_q;
    logic       en_q;
    logic       nib_v;
    logic       half, half_nxt;
    logic [3:0] low_nib, low_nib_nxt;
    logic       low_er, low_er_nxt;
    logic [7:0] pre_cnt, pre_cnt_nxt;
    logic       bad, bad_nxt;
    logic       first, first_nxt;

    logic [7:0] data_nxt;
    logic       v_nxt, er_nxt, start_nxt, end_nxt, fbad_nxt;

    logic       gig, spd_chg;
    logic       unit_v, unit_en, unit_er;
    logic [7:0] unit_val;
    logic       is_pre, is_sfd;

    // Decode the current unit for the active speed.
    always_comb begin
        gig      = speed_i[1];
        spd_chg  = (speed_i != speed_q);
        unit_v   = 1'b0;
        unit_en  = 1'b0;
        unit_er  = 1'b0;
        unit_val = 8'h00;
        is_pre   = 1'b0;
        is_sfd   = 1'b0;
        if (gig) begin
            unit_v   = !spd_chg;
            unit_en  = tx_ctl_1_i;
            unit_er  = tx_ctl_1_i ^ tx_ctl_2_i;
            unit_val = {txd_2_i, txd_1_i};
            is_pre   = (unit_val == 8'h55);
            is_sfd   = (unit_val == 8'hD5);
        end else begin
            unit_v   = !spd_chg && sample_fall_i && nib_v;
            unit_en  = en_q;
            unit_er  = en_q ^ tx_ctl_1_i;
            unit_val = {4'h0, nib_q};
            is_pre   = (nib_q == 4'h5);
            is_sfd   = (nib_q == 4'hD);
        end
    end

    // Capture the 10/100 nibble and TX_EN on the rising strobe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            nib_q <= 4'h0;
            en_q  <= 1'b0;
            nib_v <= 1'b0;
        end else if (spd_chg) begin
            nib_v <= 1'b0;
        end else if (!gig && sample_rise_i) begin
            nib_q <= txd_1_i;
            en_q  <= tx_ctl_1_i;
            nib_v <= 1'b1;
        end else if (!gig && unit_v) begin
            nib_v <= 1'b0;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        half_nxt    = half;
        low_nib_nxt = low_nib;
        low_er_nxt  = low_er;
        pre_cnt_nxt = pre_cnt;
        bad_nxt     = bad;
        first_nxt   = first;
        data_nxt    = rx_data_o;
        v_nxt       = 1'b0;
        er_nxt      = 1'b0;
        start_nxt   = 1'b0;
        end_nxt     = 1'b0;
        fbad_nxt    = 1'b0;
        if (spd_chg) begin
            half_nxt = 1'b0;
            if (state != IDLE) begin
                state_nxt = IDLE;
                end_nxt   = 1'b1;
                fbad_nxt  = 1'b1;
            end
        end else if (unit_v) begin
            case (state)
                IDLE: begin
                    if (unit_en) begin
                        if (is_pre) begin
                            state_nxt   = PRE;
                            pre_cnt_nxt = 8'd1;
                        end else begin
                            state_nxt = DROP;
                        end
                    end
                end
                PRE: begin
                    if (!unit_en) begin
                        state_nxt = IDLE;
                        end_nxt   = 1'b1;
                        fbad_nxt  = 1'b1;
                    end else if (is_pre) begin
                        if (pre_cnt != 8'hFF) pre_cnt_nxt = pre_cnt + 8'd1;
                    end else if (is_sfd && pre_cnt >= min_pre) begin
                        state_nxt = DATA;
                        half_nxt  = 1'b0;
                        bad_nxt   = 1'b0;
                        first_nxt = 1'b1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
                DATA: begin
                    if (!unit_en) begin
                        // A dangling low nibble is discarded and spoils the frame.
                        state_nxt = IDLE;
                        end_nxt   = 1'b1;
                        fbad_nxt  = bad | half;
                        half_nxt  = 1'b0;
                    end else if (gig) begin
                        v_nxt     = 1'b1;
                        data_nxt  = unit_val;
                        er_nxt    = unit_er;
                        start_nxt = first;
                        first_nxt = 1'b0;
                        bad_nxt   = bad | unit_er;
                    end else if (!half) begin
                        low_nib_nxt = unit_val[3:0];
                        low_er_nxt  = unit_er;
                        half_nxt    = 1'b1;
                    end else begin
                        v_nxt     = 1'b1;
                        data_nxt  = {unit_val[3:0], low_nib};
                        er_nxt    = unit_er | low_er;
                        start_nxt = first;
                        first_nxt = 1'b0;
                        half_nxt  = 1'b0;
                        bad_nxt   = bad | unit_er | low_er;
                    end
                end
                DROP: begin
                    if (!unit_en) begin
                        state_nxt = IDLE;
                        end_nxt   = 1'b1;
                        fbad_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state, assembly context and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            speed_q       <= 2'b00;
            half          <= 1'b0;
            low_nib       <= 4'h0;
            low_er        <= 1'b0;
            pre_cnt       <= 8'h00;
            bad           <= 1'b0;
            first         <= 1'b0;
            rx_data_o     <= 8'h00;
            rx_v_o        <= 1'b0;
            rx_er_o       <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            frame_bad_o   <= 1'b0;
        end else begin
            state         <= state_nxt;
            speed_q       <= speed_i;
            half          <= half_nxt;
            low_nib       <= low_nib_nxt;
            low_er        <= low_er_nxt;
            pre_cnt       <= pre_cnt_nxt;
            bad           <= bad_nxt;
            first         <= first_nxt;
            rx_data_o     <= data_nxt;
            rx_v_o        <= v_nxt;
            rx_er_o       <= er_nxt;
            frame_start_o <= start_nxt;
            frame_end_o   <= end_nxt;
            frame_bad_o   <= fbad_nxt;
        end
    end

    // Saturating good/bad frame counters, bumped as each frame ends.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_count_o <= '0;
            err_count_o   <= '0;
        end else if (end_nxt) begin
            if (fbad_nxt) begin
                if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
            end else begin
                if (frame_count_o != '1) frame_count_o <= frame_count_o + 1'b1;
            end
        end
    end

`ifdef RGMII_TX_SINK_INBAND_STATUS_EN
    // In-band status from interframe symbols; holds while a frame is active.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            link_o       <= 1'b0;
            link_speed_o <= 2'b00;
            duplex_o     <= 1'b0;
        end else if (unit_v && !unit_en && !unit_er) begin
            link_o       <= unit_val[0];
            link_speed_o <= unit_val[2:1];
            duplex_o     <= unit_val[3];
        end
    end
`endif

endmodule

// File: tb/tb_rgmii_tx_sink.sv
// Directed bench for rgmii_tx_sink, built with 4-bit counters so saturation
// is reachable in a handful of frames.
module tb_rgmii_tx_sink;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [1:0] speed_i = 2'b10;
    logic       sample_rise_i = 1'b1;
    logic       sample_fall_i = 1'b0;
    logic [3:0] txd_1_i = 4'h0;
    logic [3:0] txd_2_i = 4'h0;
    logic       tx_ctl_1_i = 1'b0;
    logic       tx_ctl_2_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_v_o, rx_er_o, frame_start_o, frame_end_o, frame_bad_o;
    logic [3:0] frame_count_o, err_count_o;
`ifdef RGMII_TX_SINK_INBAND_STATUS_EN
    logic       link_o;
    logic [1:0] link_speed_o;
    logic       duplex_o;
`endif

    rgmii_tx_sink #(.cnt_width_p(4), .min_preamble_p(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .speed_i(speed_i),
        .sample_rise_i(sample_rise_i), .sample_fall_i(sample_fall_i),
        .txd_1_i(txd_1_i), .txd_2_i(txd_2_i),
        .tx_ctl_1_i(tx_ctl_1_i), .tx_ctl_2_i(tx_ctl_2_i),
        .rx_data_o(rx_data_o), .rx_v_o(rx_v_o), .rx_er_o(rx_er_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .frame_bad_o(frame_bad_o),
        .frame_count_o(frame_count_o), .err_count_o(err_count_o)
`ifdef RGMII_TX_SINK_INBAND_STATUS_EN
        , .link_o(link_o), .link_speed_o(link_speed_o), .duplex_o(duplex_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       start;
        logic       er;
        logic [7:0] data;
    } rec_t;

    rec_t bq[$];
    logic eq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Record every emitted byte and frame end, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!reset_i && rx_v_o) bq.push_back({frame_start_o, rx_er_o, rx_data_o});
        if (!reset_i && frame_end_o) eq.push_back(frame_bad_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic gbyte(input logic [7:0] b, input logic en, input logic er);
        sample_rise_i = 1'b1;
        sample_fall_i = 1'b0;
        txd_1_i = b[3:0];
        txd_2_i = b[7:4];
        tx_ctl_1_i = en;
        tx_ctl_2_i = en ^ er;
        @(posedge clk_i); #1;
    endtask

    // One 10/100 nibble: rise strobe on the first clock, fall strobe two later.
    task automatic nib(input logic [3:0] n, input logic en, input logic er);
        for (int c = 0; c < 5; c++) begin
            sample_rise_i = (c == 0);
            sample_fall_i = (c == 2);
            if (c == 0) begin
                txd_1_i = n;
                tx_ctl_1_i = en;
            end
            if (c == 2) tx_ctl_1_i = en ^ er;
            @(posedge clk_i); #1;
        end
        sample_rise_i = 1'b0;
        sample_fall_i = 1'b0;
    endtask

    task automatic set_speed(input logic [1:0] s);
        speed_i = s;
        sample_rise_i = 1'b0;
        sample_fall_i = 1'b0;
        tx_ctl_1_i = 1'b0;
        tx_ctl_2_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
    endtask

    function automatic rec_t get(input int i);
        rec_t r = '0;
        if (i < bq.size()) r = bq[i];
        return r;
    endfunction

    function automatic logic get_end(input int i);
        logic r = 1'bx;
        if (i < eq.size()) r = eq[i];
        return r;
    endfunction

    initial begin
        int ers;
        #1;
        chk("rst_v", {31'd0, rx_v_o}, 0);
        chk("rst_data", {24'd0, rx_data_o}, 0);
        chk("rst_end", {30'd0, frame_end_o, frame_bad_o}, 0);
        chk("rst_cnt", {24'd0, frame_count_o, err_count_o}, 0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        repeat (2) gbyte(8'h00, 1'b0, 1'b0);

        // 1000M good frame, payload 0x01..0x40
        repeat (7) gbyte(8'h55, 1'b1, 1'b0);
        gbyte(8'hD5, 1'b1, 1'b0);
        chk("g_nov_sfd", {31'd0, rx_v_o}, 0);
        gbyte(8'h01, 1'b1, 1'b0);
        chk("g_lat", {22'd0, rx_v_o, frame_start_o, rx_data_o}, {22'd0, 2'b11, 8'h01});
        for (int i = 2; i <= 64; i++) gbyte(8'(i), 1'b1, 1'b0);
        repeat (3) gbyte(8'h00, 1'b0, 1'b0);
        chk("g_nbytes", bq.size(), 64);
        ers = 0;
        for (int i = 0; i < 64; i++) begin
            if (get(i).data != 8'(i + 1)) ers++;
            if (get(i).start != (i == 0)) ers++;
            if (get(i).er) ers++;
        end
        chk("g_bytes_bad", ers, 0);
        chk("g_nend", eq.size(), 1);
        chk("g_bad", {31'd0, get_end(0)}, 0);
        chk("g_cnt", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'd1, 4'd0});
        bq.delete(); eq.delete();

        // 100M good frame: 0x3C, 0xA7
        set_speed(2'b01);
        repeat (2) nib(4'h0, 1'b0, 1'b0);
        repeat (15) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'hC, 1'b1, 1'b0);
        nib(4'h3, 1'b1, 1'b0);
        nib(4'h7, 1'b1, 1'b0);
        nib(4'hA, 1'b1, 1'b0);
        repeat (2) nib(4'h0, 1'b0, 1'b0);
        chk("m_nbytes", bq.size(), 2);
        chk("m_b0", {23'd0, get(0)}, {23'd0, 1'b1, 1'b0, 8'h3C});
        chk("m_b1", {23'd0, get(1)}, {23'd0, 1'b0, 1'b0, 8'hA7});
        chk("m_end", {30'd0, eq.size() == 1, get_end(0)}, 2'b10);
        chk("m_cnt", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'd2, 4'd0});
        bq.delete(); eq.delete();

        // 1000M frame with TX_ER on byte index 10
        set_speed(2'b10);
        repeat (7) gbyte(8'h55, 1'b1, 1'b0);
        gbyte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) gbyte(8'h80 + 8'(i), 1'b1, (i == 10));
        repeat (2) gbyte(8'h00, 1'b0, 1'b0);
        chk("e_nbytes", bq.size(), 16);
        ers = 0;
        for (int i = 0; i < 16; i++) if (get(i).er) ers++;
        chk("e_ercount", ers, 1);
        chk("e_erbyte", {23'd0, get(10)}, {23'd0, 1'b0, 1'b1, 8'h8A});
        chk("e_end", {30'd0, eq.size() == 1, get_end(0)}, 2'b11);
        chk("e_cnt", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'd2, 4'd1});
        bq.delete(); eq.delete();

        // 10M frame ending on an odd nibble: one byte 0x21, then bad end
        set_speed(2'b00);
        repeat (3) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b0);
        nib(4'h2, 1'b1, 1'b0);
        nib(4'h3, 1'b1, 1'b0);
        repeat (2) nib(4'h0, 1'b0, 1'b0);
        chk("o_byte", {22'd0, bq.size() == 1, get(0)}, {22'd0, 1'b1, 1'b1, 1'b0, 8'h21});
        chk("o_end", {30'd0, eq.size() == 1, get_end(0)}, 2'b11);
        chk("o_err", {28'd0, err_count_o}, 2);
        bq.delete(); eq.delete();

        // 10M bad preamble 0x5, 0x7: dropped
        nib(4'h5, 1'b1, 1'b0);
        nib(4'h7, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b0);
        nib(4'h2, 1'b1, 1'b0);
        repeat (2) nib(4'h0, 1'b0, 1'b0);
        chk("p_nbytes", bq.size(), 0);
        chk("p_end", {30'd0, eq.size() == 1, get_end(0)}, 2'b11);
        chk("p_cnt", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'd2, 4'd3});
        bq.delete(); eq.delete();

        // Speed change 1000M -> 100M mid-DATA aborts on the next clock
        set_speed(2'b10);
        repeat (7) gbyte(8'h55, 1'b1, 1'b0);
        gbyte(8'hD5, 1'b1, 1'b0);
        gbyte(8'hAA, 1'b1, 1'b0);
        gbyte(8'hBB, 1'b1, 1'b0);
        speed_i = 2'b01;
        gbyte(8'hCC, 1'b1, 1'b0);
        chk("a_abort", {29'd0, frame_end_o, frame_bad_o, rx_v_o}, 3'b110);
        sample_rise_i = 1'b0;
        tx_ctl_1_i = 1'b0;
        repeat (2) nib(4'h0, 1'b0, 1'b0);
        chk("a_nbytes", bq.size(), 2);
        chk("a_cnt", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'd2, 4'd4});
        bq.delete(); eq.delete();
        repeat (7) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'hA, 1'b1, 1'b0);
        nib(4'h5, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b0);
        repeat (2) nib(4'h0, 1'b0, 1'b0);
        chk("r_b0", {23'd0, get(0)}, {23'd0, 1'b1, 1'b0, 8'h5A});
        chk("r_b1", {23'd0, get(1)}, {23'd0, 1'b0, 1'b0, 8'h11});
        chk("r_end", {30'd0, eq.size() == 1, get_end(0)}, 2'b10);
        chk("r_cnt", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'd3, 4'd4});
        bq.delete(); eq.delete();

        // Async reset mid-frame clears outputs immediately
        repeat (3) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h9, 1'b1, 1'b0);
        chk("x_pre_data", {24'd0, rx_data_o}, 8'h11);
        #2 reset_i = 1'b1;
        #1;
        chk("x_data", {24'd0, rx_data_o}, 0);
        chk("x_flags", {27'd0, rx_v_o, rx_er_o, frame_start_o, frame_end_o, frame_bad_o}, 0);
        chk("x_cnt", {24'd0, frame_count_o, err_count_o}, 0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        bq.delete(); eq.delete();

        // Saturation of the 4-bit good-frame counter
        set_speed(2'b10);
        for (int f = 0; f < 17; f++) begin
            gbyte(8'h55, 1'b1, 1'b0);
            gbyte(8'hD5, 1'b1, 1'b0);
            gbyte(8'h77, 1'b1, 1'b0);
            repeat (2) gbyte(8'h00, 1'b0, 1'b0);
            if (f == 14) chk("s_15", {28'd0, frame_count_o}, 4'hF);
        end
        chk("s_17", {24'd0, frame_count_o, err_count_o}, {24'd0, 4'hF, 4'h0});
        chk("s_nend", eq.size(), 17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
